mi_nios_irq_ctrl: RTL and testbench

Interrupt aggregator that sits directly downstream of the interval timer and the other peripheral irq outputs, and directly upstream of the Nios II CPU irq input. It latches up to NUM_SRC source requests into a pending register and applies a mask. It presents one combined irq to the CPU and a priority vector, all through a 16-bit Avalon-MM slave with the same register-read style as the timer.

---
 rtl/mi_nios_irq_ctrl.sv | 159 +++++++++++++++
 tb/tb_mi_nios_irq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mi_nios_irq_ctrl.sv
// mi_nios_irq_ctrl: interrupt aggregator between the peripheral irq lines
// and the Nios II CPU irq input. Sources are registered, latched into a
// pending register and gated by a mask. Everything is visible through a
// 16-bit Avalon-MM slave with one-cycle registered read data.
//
// Optional feature macro: MI_NIOS_IRQ_CTRL_EDGE_EN
//   defined   -> EDGE register is read/write, per-source rising-edge mode
//   undefined -> all sources level-sensitive, EDGE reads 0
//
// Internal state is kept 16 bits wide. Bits at or above NUM_SRC are
// forced to 0 by SRC_MASK, so they read 0 and are pruned in synthesis.
module mi_nios_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [15:0]         writedata,
    input  logic [NUM_SRC-1:0]  irq_src,
    output logic [15:0]         readdata,
    output logic                irq
);

    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_RAW     = 3'd2;
    localparam logic [2:0] ADDR_VECTOR  = 3'd3;
    localparam logic [2:0] ADDR_EDGE    = 3'd4;
    localparam logic [2:0] ADDR_SWTRIG  = 3'd5;

    logic [15:0] src_q_r;
    logic [15:0] pending_r;
    logic [15:0] mask_r;
    logic [15:0] readdata_r;

    logic        wr_en_s;
    logic [15:0] wdata_s;
    logic [15:0] clr_s;
    logic [15:0] sw_s;
    logic [15:0] set_s;
    logic [15:0] active_s;
    logic [15:0] vector_s;
    logic [15:0] edge_rd_s;
    logic [15:0] rd_mux_s;

    // Lowest set bit index of a 16-bit vector, 0 if none set.
    function automatic logic [3:0] lowest_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign wr_en_s  = chipselect & ~write_n;
    assign wdata_s  = writedata & SRC_MASK;
    assign active_s = pending_r & mask_r;

`ifdef MI_NIOS_IRQ_CTRL_EDGE_EN
    logic [15:0] src_d_r;
    logic [15:0] edge_mode_r;

    // Delayed source copy and edge-mode register (edge feature only).
    always_ff @(posedge clk) begin
        if (reset) begin
            src_d_r     <= 16'h0000;
            edge_mode_r <= 16'h0000;
        end else begin
            src_d_r <= src_q_r;
            if (wr_en_s && (address == ADDR_EDGE)) begin
                edge_mode_r <= wdata_s;
            end else begin
                edge_mode_r <= edge_mode_r;
            end
        end
    end

    // Per-source set term: edge-mode sources only fire on a rising edge.
    always_comb begin
        set_s     = (src_q_r & ~edge_mode_r) | (src_q_r & ~src_d_r & edge_mode_r);
        edge_rd_s = edge_mode_r;
    end
`else
    // Per-source set term: every source is level-sensitive.
    always_comb begin
        set_s     = src_q_r;
        edge_rd_s = 16'h0000;
    end
`endif

    // Write-1-to-clear and software-trigger terms from the bus.
    always_comb begin
        clr_s = 16'h0000;
        sw_s  = 16'h0000;
        if (wr_en_s && (address == ADDR_PENDING)) begin
            clr_s = wdata_s;
        end else begin
            clr_s = 16'h0000;
        end
        if (wr_en_s && (address == ADDR_SWTRIG)) begin
            sw_s = wdata_s;
        end else begin
            sw_s = 16'h0000;
        end
    end

    // VECTOR register: any-active flag in bit 15, lowest active index in 3:0.
    always_comb begin
        vector_s       = 16'h0000;
        vector_s[15]   = |active_s;
        vector_s[3:0]  = lowest_index(active_s);
    end

    // Read data mux; registered below independent of chipselect.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (address)
            ADDR_PENDING: rd_mux_s = pending_r;
            ADDR_MASK:    rd_mux_s = mask_r;
            ADDR_RAW:     rd_mux_s = src_q_r;
            ADDR_VECTOR:  rd_mux_s = vector_s;
            ADDR_EDGE:    rd_mux_s = edge_rd_s;
            default:      rd_mux_s = 16'h0000;
        endcase
    end

    // Source sampling, pending/mask update and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q_r    <= 16'h0000;
            pending_r  <= 16'h0000;
            mask_r     <= 16'h0000;
            readdata_r <= 16'h0000;
        end else begin
            src_q_r    <= 16'(irq_src) & SRC_MASK;
            // Set and software-set are ORed after the clear so no event is lost.
            pending_r  <= ((pending_r & ~clr_s) | set_s | sw_s) & SRC_MASK;
            readdata_r <= rd_mux_s;
            if (wr_en_s && (address == ADDR_MASK)) begin
                mask_r <= wdata_s;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign readdata = readdata_r;
    assign irq      = |active_s;

endmodule

// File: tb/tb_mi_nios_irq_ctrl.sv
// Directed self-checking bench for mi_nios_irq_ctrl (NUM_SRC = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mi_nios_irq_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [7:0]  irq_src;
    logic [15:0] readdata;
    logic        irq;

    int n_checks;
    int n_errors;

    mi_nios_irq_ctrl #(.NUM_SRC(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .irq_src    (irq_src),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
    endtask

    task automatic bus_read(input logic [2:0] a, input string tag, input logic [15:0] exp);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        check_val(tag, readdata, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_src    = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state: every address reads 0, irq low.
        check_val("reset_irq", {15'd0, irq}, 16'h0000);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), $sformatf("reset_rd%0d", a), 16'h0000);
        end

        // Timer pulse on source 0 with latency check.
        bus_write(3'd1, 16'h0001);
        irq_src = 8'h01;
        @(negedge clk);
        irq_src = 8'h00;
        check_val("lat_e1_irq", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        check_val("lat_e2_irq", {15'd0, irq}, 16'h0001);
        bus_read(3'd0, "t_pending", 16'h0001);
        bus_read(3'd3, "t_vector", 16'h8000);
        bus_write(3'd0, 16'h0001);
        check_val("t_w1c_irq", {15'd0, irq}, 16'h0000);
        bus_read(3'd0, "t_pend_clr", 16'h0000);

        // Level sources 2 and 5 held high, only 5 masked in.
        bus_write(3'd1, 16'h0020);
        irq_src = 8'h24;
        repeat (3) @(negedge clk);
        bus_read(3'd3, "lv_vector", 16'h8005);
        bus_read(3'd0, "lv_pending", 16'h0024);
        bus_read(3'd2, "lv_raw", 16'h0024);
        bus_write(3'd0, 16'h00FF);
        bus_read(3'd0, "lv_reset_after_clr", 16'h0024);
        irq_src = 8'h00;
        repeat (2) @(negedge clk);
        bus_write(3'd0, 16'h00FF);
        bus_read(3'd0, "lv_cleared", 16'h0000);

        // Software trigger, then mask off keeps pending.
        bus_write(3'd1, 16'h0080);
        check_val("sw_pre_irq", {15'd0, irq}, 16'h0000);
        bus_write(3'd5, 16'h0080);
        check_val("sw_irq", {15'd0, irq}, 16'h0001);
        bus_read(3'd0, "sw_pending", 16'h0080);
        bus_read(3'd5, "sw_rd_zero", 16'h0000);
        bus_write(3'd1, 16'h0000);
        check_val("sw_mask_off_irq", {15'd0, irq}, 16'h0000);
        bus_read(3'd0, "sw_pend_kept", 16'h0080);
        bus_write(3'd0, 16'h0080);

        // Upper writedata bits ignored; RAW and unused addresses not writable.
        bus_write(3'd1, 16'hFF00);
        bus_read(3'd1, "mask_upper", 16'h0000);
        bus_write(3'd2, 16'h00FF);
        bus_read(3'd2, "raw_ro", 16'h0000);
        bus_write(3'd6, 16'hFFFF);
        bus_read(3'd6, "addr6", 16'h0000);

        // Set wins over a simultaneous W1C of the same bit.
        irq_src = 8'h04;
        @(negedge clk);
        irq_src    = 8'h00;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 16'h0004;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        bus_read(3'd0, "set_vs_clr", 16'h0004);
        bus_write(3'd0, 16'h0004);
        bus_read(3'd0, "set_vs_clr_after", 16'h0000);

        // Read of PENDING in the W1C cycle returns the pre-write value.
        bus_write(3'd5, 16'h0010);
        bus_write(3'd0, 16'h0010);
        check_val("w1c_same_cycle_rd", readdata, 16'h0010);
        bus_read(3'd0, "w1c_after", 16'h0000);

        // Reset mid-stream with all sources high.
        bus_write(3'd1, 16'h00FF);
        irq_src = 8'hFF;
        repeat (3) @(negedge clk);
        check_val("pre_rst_irq", {15'd0, irq}, 16'h0001);
        address = 3'd0;
        reset   = 1'b1;
        @(negedge clk);
        check_val("rst_irq", {15'd0, irq}, 16'h0000);
        check_val("rst_readdata", readdata, 16'h0000);
        irq_src = 8'h00;
        reset   = 1'b0;
        bus_read(3'd1, "rst_mask", 16'h0000);
        bus_read(3'd0, "rst_pending", 16'h0000);

`ifdef MI_NIOS_IRQ_CTRL_EDGE_EN
        // Edge mode on source 1: one pending per rising edge.
        bus_write(3'd4, 16'h0002);
        bus_read(3'd4, "edge_rd", 16'h0002);
        bus_write(3'd1, 16'h0002);
        irq_src = 8'h02;
        repeat (3) @(negedge clk);
        bus_read(3'd0, "edge_first", 16'h0002);
        bus_write(3'd0, 16'h0002);
        repeat (5) @(negedge clk);
        bus_read(3'd0, "edge_held", 16'h0000);
        check_val("edge_held_irq", {15'd0, irq}, 16'h0000);
        irq_src = 8'h00;
        repeat (2) @(negedge clk);
        irq_src = 8'h02;
        repeat (3) @(negedge clk);
        bus_read(3'd0, "edge_second", 16'h0002);
        irq_src = 8'h00;
`else
        // Without the edge feature EDGE is not writable.
        bus_write(3'd4, 16'hFFFF);
        bus_read(3'd4, "edge_disabled", 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
